pingpong_data_mem: RTL
======================

# pingpong_data_mem

Double-buffered (ping-pong) synchronous data memory, the parametrised successor to the single-bank `data_mem`. Two banks of 2^ADDR_WIDTH words, each DATA_WIDTH bits wide. The write side fills the back bank with per-byte write enables while the read side streams from the front bank. A req/ack handshake swaps the banks between frames, so a frame is never displayed half-written.

## Interface
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 3, address width; depth per bank = 2^ADDR_WIDTH.
- BE_WIDTH, DATA_WIDTH/8, derived byte-enable width; not overridden.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  active-high; write the back bank this edge.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  BE_WIDTH  byte enables; byte i = wr_data[8i+7:8i].
- rd_en  in  1  active-high; read the front bank this edge.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  high for one cycle when rd_data is newly updated.
- swap_req  in  1  level request to exchange banks; held until swap_ack.
- swap_ack  out  1  one-cycle pulse once the swap has taken effect.
- wr_bank  out  1  index of the current back (write) bank.
- rd_bank  out  1  index of the current front (read) bank; always ~wr_bank.

## Operation
- Storage: two arrays, bank0 and bank1. Contents are not cleared by reset.
- Write: on an edge with wr_en=1, for each i with wr_be[i]=1, byte i of bank[wr_bank][wr_addr] <= wr_data byte i. Unselected bytes are unchanged. wr_be=0 makes the write a no-op.
- Read: on an edge with rd_en=1, rd_data <= bank[rd_bank][rd_addr] and rd_valid <= 1. With rd_en=0, rd_data holds its value and rd_valid <= 0.
- Reads and writes always target different banks, so a same-address read and write in one cycle never collide. The read returns the front-bank value.
- Swap FSM, state register plus wr_bank:
  - IDLE: if swap_req=1 and rd_en=0, toggle wr_bank this edge and go to ACK. If swap_req=1 and rd_en=1, go to PEND.
  - PEND: toggle wr_bank on the first edge with rd_en=0, then go to ACK. While rd_en stays 1, remain in PEND.
  - ACK: swap_ack=1 for exactly this cycle. Next edge goes to IDLE. A swap_req still high in IDLE is treated as a new request, so the requester must drop swap_req on seeing swap_ack.
- A write issued on the swap edge lands in the old back bank, which becomes the new front bank. A read on the swap edge is impossible by construction.
- swap_req dropped while in PEND: the swap still completes. The request is committed once seen.

## Timing
- Reset (reset=0 at an edge): rd_data=0, rd_valid=0, swap_ack=0, wr_bank=0, rd_bank=1, FSM=IDLE. Reset overrides all other inputs that edge. A swap in PEND is abandoned.
- Write latency 1: data written at edge N is readable from edge N+1, but only after a swap makes that bank the front bank.
- Read latency 1: rd_en sampled at edge N, rd_data/rd_valid valid after edge N.
- Swap latency from swap_req rising with rd_en=0:
  - wr_bank toggles at the first edge.
  - swap_ack is high the following cycle.
  - The first read of the new front bank may be issued in the swap_ack cycle.
- Back-to-back reads: rd_valid stays high continuously and a swap is held off indefinitely. Read streams must leave gaps to allow a swap.
- Address wrap: none internal; addresses are used as given, full range 0..2^ADDR_WIDTH-1.

## Test plan
All cases use DATA_WIDTH=16, ADDR_WIDTH=3.
- Reset state: hold reset=0 for 2 edges with random inputs -> rd_data=0000, rd_valid=0, swap_ack=0, wr_bank=0, rd_bank=1.
- Write then swap then read:
  - Write addr 0..7 with 16'h1100+addr, wr_be=11.
  - Pulse the swap handshake -> wr_bank=1, one swap_ack pulse.
  - Read addr 0..7 -> rd_data=1100..1107, each one cycle after rd_en, with rd_valid high.
- Byte enables: back bank addr 3 holds 1103.
  - Write A5A5 with wr_be=01, then 5A5A with wr_be=10.
  - After a swap, read addr 3 -> 5AA5.
  - A write with wr_be=00 leaves the word unchanged.
- Same-address read/write: front addr 2 = 1102; same cycle, write BEEF to back addr 2 and read addr 2 -> rd_data=1102. After a swap, read addr 2 -> BEEF.
- Deferred swap:
  - Raise swap_req during a 4-cycle rd_en burst -> wr_bank unchanged and swap_ack=0 for the whole burst.
  - First idle edge toggles wr_bank; swap_ack pulses the next cycle.
  - Repeat with swap_req dropped mid-burst -> the swap still completes.
- Reset mid-operation: assert reset=0 while in PEND -> no toggle, no swap_ack, wr_bank=0 after release. Memory contents are retained: after one swap, reads return the pre-reset data.

Source files
------------

// File: rtl/pingpong_data_mem.sv
// Double-buffered data memory: writes fill the back bank while reads stream from the front bank.
// Latency: write 1 cycle (visible after the next swap), read 1 cycle, swap toggles on the first read-free edge.
// Backpressure: a swap request is held off while rd_en is high; swap_ack pulses once the swap has taken effect.
module pingpong_data_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  wr_bank,
    output logic                  rd_bank
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [DATA_WIDTH-1:0] bank0 [DEPTH];
    logic [DATA_WIDTH-1:0] bank1 [DEPTH];
    logic [1:0]            state;
    logic                  swap_now;

    assign rd_bank  = ~wr_bank;
    assign swap_ack = (state == ACK);

    // Toggle only on an edge without a read, so a read never straddles a bank change.
    assign swap_now = !rd_en && ((state == PEND) || ((state == IDLE) && swap_req));

    // Storage is not cleared by reset; a reset edge still suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_be[i]) begin
                    if (wr_bank) begin
                        bank1[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                    end else begin
                        bank0[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            wr_bank <= 1'b0;
        end else begin
            if (swap_now) begin
                wr_bank <= ~wr_bank;
            end
            case (state)
                IDLE: begin
                    if (swap_req) begin
                        state <= rd_en ? PEND : ACK;
                    end
                end
                PEND: begin
                    if (!rd_en) begin
                        state <= ACK;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
